// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM states and
// flag bit positions.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL1 = 4'h4,
        OP_SHR1 = 4'h5,
        OP_ROL1 = 4'h6,
        OP_ROR1 = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DZ    = 3;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// {hi, lo} shift register pair. One iteration per step, WIDTH steps per op.
module seq_muldiv_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             last_o
);

    logic [WIDTH-1:0] lo_q, hi_q, opb_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum, div_rem, div_diff;

    // lo_o/hi_o are the values after the current iteration, so the owner can
    // capture the final answer on the same edge the last step completes.
    // NOTE: every combinational output gets a value on every path, else a latch is inferred.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_rem  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, opb_q};
        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                hi_o = div_rem[WIDTH-1:0];
                lo_o = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_o = div_diff[WIDTH-1:0];
                lo_o = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_o = mul_sum[WIDTH:1];
            lo_o = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q     <= '0;
            hi_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load_i) begin
            lo_q     <= op_a_i;
            hi_q     <= '0;
            opb_q    <= op_b_i;
            is_div_q <= is_div_i;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (step_i) begin
            lo_q     <= lo_o;
            hi_q     <= hi_o;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/ready/done handshake and registered result/flags.
// Optional SEQ_ALU_WIDE_RESULT_EN adds result_hi (product high half / remainder).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
`ifdef SEQ_ALU_WIDE_RESULT_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_res, core_lo, core_hi;
    logic [3:0]       alu_flg;
    logic [WIDTH:0]   sum;
    logic             core_load, core_step, core_last, accept;

    seq_muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .is_div_i (opcode == OP_DIV),
        .step_i   (core_step),
        .op_a_i   (operand1),
        .op_b_i   (operand2),
        .lo_o     (core_lo),
        .hi_o     (core_hi),
        .last_o   (core_last)
    );

    // Single-cycle results; the DIV arm is only used for the divide-by-zero case.
    always_comb begin
        sum     = {1'b0, operand1} + {1'b0, operand2};
        alu_res = '0;
        alu_flg = '0;
        case (opcode)
            OP_ADD:  begin alu_res = sum[WIDTH-1:0]; alu_flg[FLG_CARRY] = sum[WIDTH]; end
            OP_SUB:  begin alu_res = operand1 - operand2; alu_flg[FLG_CARRY] = operand1 < operand2; end
            OP_DIV:  begin alu_res = '1; alu_flg[FLG_DZ] = 1'b1; end
            OP_SHL1: alu_res = {operand1[WIDTH-2:0], 1'b0};
            OP_SHR1: alu_res = {1'b0, operand1[WIDTH-1:1]};
            OP_ROL1: alu_res = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
            OP_ROR1: alu_res = {operand1[0], operand1[WIDTH-1:1]};
            OP_AND:  alu_res = operand1 & operand2;
            OP_OR:   alu_res = operand1 | operand2;
            OP_XOR:  alu_res = operand1 ^ operand2;
            OP_NOR:  alu_res = ~(operand1 | operand2);
            OP_NAND: alu_res = ~(operand1 & operand2);
            OP_XNOR: alu_res = ~(operand1 ^ operand2);
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, operand1 > operand2};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, operand1 == operand2};
            default: alu_res = '0;
        endcase
        alu_flg[FLG_ZERO] = (alu_res == '0);
    end

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign accept = ready && start;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        flags_d   = flags_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        core_load = 1'b1;
                        state_d   = ST_MUL;
                    end else if (opcode == OP_DIV && operand2 != '0) begin
                        core_load = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        result_d = alu_res;
                        hi_d     = '0;
                        flags_d  = alu_flg;
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                core_step = 1'b1;
                if (core_last) begin
                    result_d          = core_lo;
                    hi_d              = core_hi;
                    flags_d           = '0;
                    flags_d[FLG_ZERO] = (core_lo == '0);
                    flags_d[FLG_OVF]  = (state_q == ST_MUL) && (core_hi != '0);
                    state_d           = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
`ifdef SEQ_ALU_WIDE_RESULT_EN
    assign result_hi = hi_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): directed cases plus random traffic,
// checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    opcode = '0;
    logic [W-1:0]  operand1 = '0, operand2 = '0;
    logic          ready, done;
    logic [W-1:0]  result;
    logic [3:0]    flags;
`ifdef SEQ_ALU_WIDE_RESULT_EN
    logic [W-1:0]  result_hi;
`endif

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .flags    (flags)
`ifdef SEQ_ALU_WIDE_RESULT_EN
        ,
        .result_hi(result_hi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   flg;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: flags are {div_zero, overflow, carry, zero}.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        logic           c, o, dz;
        e.res = '0; e.hi = '0; e.lat = 1; e.acc = 0;
        c = 1'b0; o = 1'b0; dz = 1'b0;
        case (op)
            4'h0: begin e.res = a + b; c = (32'(a) + 32'(b)) > 32'hFFFF; end
            4'h1: begin e.res = a - b; c = a < b; end
            4'h2: begin p = 32'(a) * 32'(b); e.res = p[W-1:0]; e.hi = p[2*W-1:W];
                        o = (e.hi != 0); e.lat = W + 1; end
            4'h3: if (b == 0) begin e.res = 16'hFFFF; dz = 1'b1; end
                  else begin e.res = a / b; e.hi = a % b; e.lat = W + 1; end
            4'h4: e.res = a << 1;
            4'h5: e.res = a >> 1;
            4'h6: e.res = (a << 1) | (a >> (W - 1));
            4'h7: e.res = (a >> 1) | (a << (W - 1));
            4'h8: e.res = a & b;
            4'h9: e.res = a | b;
            4'hA: e.res = a ^ b;
            4'hB: e.res = ~(a | b);
            4'hC: e.res = ~(a & b);
            4'hD: e.res = ~(a ^ b);
            4'hE: e.res = (a > b) ? 16'd1 : 16'd0;
            default: e.res = (a == b) ? 16'd1 : 16'd0;
        endcase
        e.flg = {dz, o, c, e.res == 0};
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("flags", 64'(flags), 64'(e.flg));
                check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
`ifdef SEQ_ALU_WIDE_RESULT_EN
                check("result_hi", 64'(result_hi), 64'(e.hi));
`endif
            end
        end
    end

    // Drive one start request; only push an expectation if it will be accepted.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        start = 1'b1; opcode = op; operand1 = a; operand2 = b;
        if (ready) begin
            e = model(op, a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        operand1 = W'($urandom);
        operand2 = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #12 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);

        issue(4'h0, 16'hFFFF, 16'h0001);
        drain();
        issue(4'h2, 16'd300, 16'd300);
        drain();
        issue(4'h3, 16'd100, 16'd7);
        drain();
        issue(4'h3, 16'd5, 16'd0);
        drain();

        // MUL in flight: an ADD start a few cycles later must be ignored.
        issue(4'h2, 16'd300, 16'd300);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_ready", 64'(ready), 64'd0);
            if (i == 2) begin
                start = 1'b1; opcode = 4'h0; operand1 = 16'd1; operand2 = 16'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of a DIV.
        issue(4'h3, 16'd100, 16'd7);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        issue(4'h1, 16'd3, 16'd5);
        drain();

        // Back-to-back: second start lands in the first op's DONE cycle.
        issue(4'h6, 16'h8001, 16'h0000);
        issue(4'hF, 16'h1234, 16'h1234);
        drain();

        for (int i = 0; i < 80; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) a = b;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, a, b);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
